// File: rtl/leaf_pkg.sv
// rtl/leaf_pkg.sv - shared packet layout and sizing helpers for leaf interface blocks
//
// Packet layout, MSB first: {valid, dst_leaf, dst_port, seq, payload}.
// The helpers take the field widths as arguments because the widths are
// parameters of the instantiating module, not package constants.
package leaf_pkg;

  localparam int DEF_PAYLOAD_BITS  = 32;
  localparam int DEF_NUM_LEAF_BITS = 5;
  localparam int DEF_NUM_PORT_BITS = 4;
  localparam int DEF_NUM_ADDR_BITS = 7;

  // Total packet width including the valid flag.
  function automatic int packet_bits(input int leaf_bits, input int port_bits,
                                     input int addr_bits, input int payload_bits);
    return 1 + leaf_bits + port_bits + addr_bits + payload_bits;
  endfunction

  // Field LSB offsets within a packet.
  function automatic int seq_lsb(input int payload_bits);
    return payload_bits;
  endfunction

  function automatic int dst_port_lsb(input int addr_bits, input int payload_bits);
    return addr_bits + payload_bits;
  endfunction

  function automatic int dst_leaf_lsb(input int port_bits, input int addr_bits,
                                      input int payload_bits);
    return port_bits + addr_bits + payload_bits;
  endfunction

  // Counter width able to hold 0..credit_init inclusive.
  function automatic int credit_width(input int credit_init);
    return $clog2(credit_init + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant searching from a pointer
//
// Ports:
//   req        N-bit request vector
//   ptr        index where the search starts (highest priority this cycle)
//   grant      one-hot grant, zero when no request
//   grant_idx  binary index of the granted requester
//   grant_vld  a grant was made
// Purely combinational; the caller owns the pointer update.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_credit_arbiter.sv
// rtl/leaf_credit_arbiter.sv - credit-gated round-robin merge of user output streams into one packet stream
//
// Ports:
//   clk_user, reset           clock; asynchronous active-high reset
//   din_leaf_user2interface   per-port payloads, port i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   vld_user2interface        per-port valid
//   ack_interface2user        per-port accept, one-hot or zero, combinational in the grant cycle
//   dout_pkt, pkt_ack         registered packet {valid, dst_leaf, dst_port, seq, payload}; consumed on pkt_ack
//   credit_vld/port/amt       credit return from the receiver side
//   cfg_we/port/dst_leaf/dst_port  routing table write
//   credit_err                sticky: credit overflow or out-of-range port index
module leaf_credit_arbiter
  import leaf_pkg::*;
#(
  parameter int NUM_OUT_PORTS = 4,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_LEAF_BITS = DEF_NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS = DEF_NUM_PORT_BITS,
  parameter int NUM_ADDR_BITS = DEF_NUM_ADDR_BITS,
  parameter int CREDIT_INIT   = 64,
  localparam int PACKET_BITS  = packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS,
                                            NUM_ADDR_BITS, PAYLOAD_BITS)
) (
  input  logic                                  clk_user,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [PACKET_BITS-1:0]                dout_pkt,
  input  logic                                  pkt_ack,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic [NUM_ADDR_BITS:0]                credit_amt,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dst_port,
  output logic                                  credit_err
);

  localparam int CW = credit_width(CREDIT_INIT);
  // Sum width: room for a full counter plus a maximal return without wrapping.
  localparam int SW = ((CW > NUM_ADDR_BITS + 1) ? CW : NUM_ADDR_BITS + 1) + 1;
  localparam int IW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  logic [CW-1:0]            credit_q   [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_d   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_q      [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] tbl_leaf_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] tbl_port_q [NUM_OUT_PORTS];
  logic [IW-1:0]            rr_ptr_q;

  logic                     slot_free;
  logic [NUM_OUT_PORTS-1:0] req;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic [IW-1:0]            grant_idx;
  logic                     grant_vld;

  logic [NUM_LEAF_BITS-1:0] sel_leaf;
  logic [NUM_PORT_BITS-1:0] sel_port;
  logic [NUM_ADDR_BITS-1:0] sel_seq;
  logic [PAYLOAD_BITS-1:0]  sel_payload;

  logic credit_ovf;
  logic bad_idx;

  // The slot can take a new packet when empty or when the held one leaves this cycle.
  assign slot_free = !dout_pkt[PACKET_BITS-1] || pkt_ack;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      req[i] = vld_user2interface[i] && (credit_q[i] != '0) && slot_free;
    end
  end

  rr_arbiter #(.N(NUM_OUT_PORTS)) u_rr (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign ack_interface2user = grant;

  // One-hot mux of the granted port's routing, sequence and payload.
  always_comb begin
    sel_leaf    = '0;
    sel_port    = '0;
    sel_seq     = '0;
    sel_payload = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant[i]) begin
        sel_leaf    = tbl_leaf_q[i];
        sel_port    = tbl_port_q[i];
        sel_seq     = seq_q[i];
        sel_payload = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  // Send and return on the same port in one cycle are both applied; the
  // decrement is safe because a port is only granted with credit > 0.
  always_comb begin
    logic [SW-1:0] sum;
    sum        = '0;
    credit_ovf = 1'b0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = SW'(credit_q[i]);
      if (grant[i]) sum = sum - SW'(1);
      if (credit_vld && int'(credit_port) == i) sum = sum + SW'(credit_amt);
      if (sum > SW'(CREDIT_INIT)) begin
        credit_d[i] = CW'(CREDIT_INIT);
        credit_ovf  = 1'b1;
      end else begin
        credit_d[i] = sum[CW-1:0];
      end
    end
  end

  assign bad_idx = (credit_vld && int'(credit_port) >= NUM_OUT_PORTS) ||
                   (cfg_we && int'(cfg_port) >= NUM_OUT_PORTS);

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      dout_pkt   <= '0;
      rr_ptr_q   <= '0;
      credit_err <= 1'b0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i]   <= CW'(CREDIT_INIT);
        seq_q[i]      <= '0;
        tbl_leaf_q[i] <= '0;
        tbl_port_q[i] <= NUM_PORT_BITS'(i);
      end
    end else begin
      if (grant_vld) begin
        dout_pkt <= {1'b1, sel_leaf, sel_port, sel_seq, sel_payload};
        rr_ptr_q <= (int'(grant_idx) == NUM_OUT_PORTS - 1) ? '0 : grant_idx + IW'(1);
      end else if (slot_free) begin
        dout_pkt <= '0;
      end

      if (credit_ovf || bad_idx) credit_err <= 1'b1;

      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        if (grant[i]) seq_q[i] <= seq_q[i] + 1'b1;
        // Table write lands on this edge; a same-cycle grant already used the old entry.
        if (cfg_we && int'(cfg_port) == i) begin
          tbl_leaf_q[i] <= cfg_dst_leaf;
          tbl_port_q[i] <= cfg_dst_port;
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_credit_arbiter.sv
// tb/tb_leaf_credit_arbiter.sv - scoreboard bench for leaf_credit_arbiter
module tb_leaf_credit_arbiter;

  localparam int N   = 4;
  localparam int PB  = 32;
  localparam int LB  = 5;
  localparam int PTB = 4;
  localparam int AB  = 7;
  localparam int PKB = 1 + LB + PTB + AB + PB;

  logic             clk_user = 1'b0;
  logic             reset    = 1'b1;
  logic [N*PB-1:0]  din;
  logic [N-1:0]     vld      = '0;
  logic [N-1:0]     ack;
  logic [PKB-1:0]   dout_pkt;
  logic             pkt_ack  = 1'b1;
  logic             credit_vld  = 1'b0;
  logic [PTB-1:0]   credit_port = '0;
  logic [AB:0]      credit_amt  = '0;
  logic             cfg_we      = 1'b0;
  logic [PTB-1:0]   cfg_port    = '0;
  logic [LB-1:0]    cfg_dst_leaf = '0;
  logic [PTB-1:0]   cfg_dst_port = '0;
  logic             credit_err;

  int total = 0;
  int bad   = 0;

  logic [PKB-1:0] exp_q[$];
  logic [PB-1:0]  pay     [N];
  logic [AB-1:0]  exp_seq [N];
  logic [LB-1:0]  tl      [N];
  logic [PTB-1:0] tp      [N];

  assign din = {pay[3], pay[2], pay[1], pay[0]};

  always #5 clk_user = ~clk_user;

  leaf_credit_arbiter dut (
    .clk_user                (clk_user),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .dout_pkt                (dout_pkt),
    .pkt_ack                 (pkt_ack),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port),
    .credit_amt              (credit_amt),
    .cfg_we                  (cfg_we),
    .cfg_port                (cfg_port),
    .cfg_dst_leaf            (cfg_dst_leaf),
    .cfg_dst_port            (cfg_dst_port),
    .credit_err              (credit_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_user);
    #1;
  endtask

  function automatic logic [PKB-1:0] mk_pkt(input int g);
    return {1'b1, tl[g], tp[g], exp_seq[g], pay[g]};
  endfunction

  task automatic push_exp(input int g);
    exp_q.push_back(mk_pkt(g));
    exp_seq[g] = exp_seq[g] + 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      exp_seq[i] = '0;
      tl[i]      = '0;
      tp[i]      = PTB'(i);
    end
  endtask

  task automatic do_reset();
    vld = '0; credit_vld = 1'b0; cfg_we = 1'b0; pkt_ack = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Monitor: every packet consumed downstream must match the next expected one.
  initial begin
    logic [PKB-1:0] e;
    forever begin
      @(negedge clk_user);
      if (!reset && dout_pkt[PKB-1] && pkt_ack) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_unexpected: got %h expected none", dout_pkt);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard_pkt", 64'(dout_pkt), 64'(e));
        end
      end
    end
  end

  initial begin
    int n;
    logic [PKB-1:0] held;
    pay[0] = 32'h1111_0000;
    pay[1] = 32'h2222_0001;
    pay[2] = 32'hDEAD_BEEF;
    pay[3] = 32'h4444_0003;
    model_reset();
    step();
    step();
    reset = 1'b0;

    // Reset state
    @(negedge clk_user);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_dout", 64'(dout_pkt), 64'(0));
    check("rst_err", 64'(credit_err), 64'(0));

    // Single packet on port 2
    step();
    vld = 4'b0100;
    @(negedge clk_user);
    check("t1_ack", 64'(ack), 64'(4'b0100));
    push_exp(2);
    step();
    vld = '0;
    @(negedge clk_user);
    check("t1_ack_once", 64'(ack), 64'(0));

    // Round robin with all ports valid
    do_reset();
    vld = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_user);
      check("t2_order", 64'(ack), 64'(onehot(k % N)));
      push_exp(k % N);
      step();
    end
    vld = '0;

    // Credit exhaustion and return on port 1
    do_reset();
    vld = 4'b0010;
    n = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_user);
      if (ack[1]) begin n++; push_exp(1); end
      step();
    end
    check("t3_acks_64", 64'(n), 64'(64));
    credit_vld = 1'b1; credit_port = 4'd1; credit_amt = 8'd3;
    @(negedge clk_user);
    check("t3_stalled", 64'(ack), 64'(0));
    step();
    credit_vld = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_user);
      if (ack[1]) begin n++; push_exp(1); end
      step();
    end
    check("t3_acks_3", 64'(n), 64'(3));
    vld = '0;

    // Backpressure: slot held while pkt_ack=0
    do_reset();
    pkt_ack = 1'b0;
    vld = 4'b0011;
    @(negedge clk_user);
    check("t4_first_ack", 64'(ack), 64'(4'b0001));
    held = mk_pkt(0);
    push_exp(0);
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_user);
      check("t4_no_ack", 64'(ack), 64'(0));
      check("t4_hold", 64'(dout_pkt), 64'(held));
      step();
    end
    pkt_ack = 1'b1;
    @(negedge clk_user);
    check("t4_release_ack", 64'(ack), 64'(4'b0010));
    push_exp(1);
    step();
    vld = '0;

    // Routing write racing a grant, then overflow on a full port
    do_reset();
    vld = 4'b0001;
    cfg_we = 1'b1; cfg_port = 4'd0; cfg_dst_leaf = 5'd17; cfg_dst_port = 4'd9;
    @(negedge clk_user);
    check("t5_ack_a", 64'(ack), 64'(4'b0001));
    push_exp(0);
    step();
    cfg_we = 1'b0;
    tl[0] = 5'd17;
    tp[0] = 4'd9;
    @(negedge clk_user);
    check("t5_ack_b", 64'(ack), 64'(4'b0001));
    push_exp(0);
    step();
    vld = '0;
    @(negedge clk_user);
    check("t5_err_clear", 64'(credit_err), 64'(0));
    step();
    credit_vld = 1'b1; credit_port = 4'd2; credit_amt = 8'd10;
    step();
    credit_vld = 1'b0;
    @(negedge clk_user);
    check("t5_err_ovf", 64'(credit_err), 64'(1));
    step();
    vld = 4'b0100;
    n = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_user);
      if (ack[2]) begin n++; push_exp(2); end
      step();
    end
    check("t5_clamped_64", 64'(n), 64'(64));
    vld = '0;

    // Out-of-range indices
    do_reset();
    credit_vld = 1'b1; credit_port = 4'd7; credit_amt = 8'd1;
    step();
    credit_vld = 1'b0;
    @(negedge clk_user);
    check("t5_err_credit_idx", 64'(credit_err), 64'(1));
    do_reset();
    @(negedge clk_user);
    check("t5_err_reset", 64'(credit_err), 64'(0));
    step();
    cfg_we = 1'b1; cfg_port = 4'd5; cfg_dst_leaf = 5'd3; cfg_dst_port = 4'd3;
    step();
    cfg_we = 1'b0;
    @(negedge clk_user);
    check("t5_err_cfg_idx", 64'(credit_err), 64'(1));

    // Sequence wrap on port 3 at full rate with matching returns
    do_reset();
    vld = 4'b1000;
    credit_vld = 1'b1; credit_port = 4'd3; credit_amt = 8'd1;
    n = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk_user);
      if (ack[3]) begin n++; push_exp(3); end
      step();
    end
    vld = '0;
    credit_vld = 1'b0;
    check("t6_acks_130", 64'(n), 64'(130));
    check("t6_no_err", 64'(credit_err), 64'(0));

    repeat (4) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaf_credit_arbiter.md
# leaf_credit_arbiter

Parametrised output-side arbiter for a leaf. It merges NUM_OUT_PORTS user output streams, each using the ap_vld/ap_ack handshake, into a single BFT packet stream. Each port has a programmable destination (leaf, port), a per-port credit counter that blocks sends when the receiver has no free space, and a per-port sequence number. It sits between the user kernel's Output_N ports and the BFT-facing packet register of the leaf interface. It generalises the fixed 4-output interface path to any port count, with credit flow control and runtime-configurable routing.

## Interface
- NUM_OUT_PORTS, 4, number of user output streams (1..16)
- PAYLOAD_BITS, 32, payload width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, sequence field width
- CREDIT_INIT, 64, credits per port after reset; also the saturation ceiling
- PACKET_BITS, 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS (49), derived

Ports:
- clk_user  in  1  sole clock
- reset  in  1  asynchronous, active-high
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  port i occupies slice [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_user2interface  in  NUM_OUT_PORTS  per-port data valid
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept, one-hot or zero
- dout_pkt  out  PACKET_BITS  {valid, dst_leaf, dst_port, seq, payload}, valid is the MSB
- pkt_ack  in  1  downstream consumes dout_pkt this cycle
- credit_vld  in  1  credit return strobe
- credit_port  in  NUM_PORT_BITS  local port index being credited
- credit_amt  in  NUM_ADDR_BITS+1  credits returned
- cfg_we  in  1  routing table write
- cfg_port  in  NUM_PORT_BITS  table entry index
- cfg_dst_leaf  in  NUM_LEAF_BITS  destination leaf
- cfg_dst_port  in  NUM_PORT_BITS  destination port
- credit_err  out  1  sticky; set on credit overflow or on an out-of-range index

## Operation
- A port is eligible when vld[i]=1, credit[i]>0 and the output slot is free. The slot is free when dout_pkt valid=0, or when valid=1 and pkt_ack=1 in the same cycle.
- A round-robin picks one eligible port. Search starts at rr_ptr. On a grant, rr_ptr becomes (granted+1) mod NUM_OUT_PORTS.
- ack_interface2user[g] is asserted combinationally in the grant cycle. On that edge:
  - dout_pkt captures {1, table[g], seq[g], payload[g]}.
  - seq[g] increments, wrapping modulo 2^NUM_ADDR_BITS.
  - credit[g] decrements.
- Non-granted ports hold their data. The user must keep vld and data stable until acked.
- dout_pkt holds its value until pkt_ack. After pkt_ack with no new grant, dout_pkt goes all-zero.
- Credit update rule: next = credit − sent + (credit_vld && credit_port==i ? credit_amt : 0). Same-cycle send and return on one port are both applied.
  - If the result exceeds CREDIT_INIT, it clamps to CREDIT_INIT and credit_err is set.
  - A credit_port or cfg_port value ≥ NUM_OUT_PORTS is ignored and sets credit_err.
- cfg_we writes the table entry on the edge. A grant to that port in the same cycle uses the old entry.
- Reset values:
  - ack_interface2user = 0, dout_pkt = 0, credit_err = 0.
  - All credits = CREDIT_INIT, all seq = 0, rr_ptr = 0.
  - Table entry i = {leaf 0, port i}.
- Reset asserted mid-packet drops the held packet. Nothing is replayed.

## Timing
- Grant to dout_pkt valid: 1 cycle.
- Back-to-back sustained throughput is 1 packet/cycle while pkt_ack=1.
- ack is never asserted while the slot is busy and pkt_ack=0.
- A port with credit 0 is skipped. A return arriving in cycle t makes the port eligible in cycle t+1.
- Credit counters are $clog2(CREDIT_INIT+1) bits wide and never go below zero.

## Structure
- Package leaf_pkg holds:
  - packet field offsets and widths;
  - the PACKET_BITS derivation;
  - the credit-width function.
- Sub-module rr_arbiter (parameter N) takes a request vector and pointer and returns a one-hot grant plus a valid flag. It is reused by input-side demux blocks.
- The routing table, credits and seq are held in flops, not BRAM, for single-cycle access.

## Test plan
- Reset, then drive port 2 with vld and payload 0xDEADBEEF, pkt_ack=1 → ack[2] pulses once; the next cycle dout_pkt = {1, leaf 0, port 2, seq 0, 0xDEADBEEF}.
- All 4 ports valid continuously with pkt_ack=1 → grants in order 0,1,2,3,0…; each port's seq increments by 1 per grant.
- Port 1 only, with CREDIT_INIT=64 and no returns → exactly 64 acks, then stall. Then credit_vld with port 1 and amount 3 → exactly 3 more packets.
- Hold pkt_ack=0 for 5 cycles with ports valid → dout_pkt stays constant and no ack is asserted; the first pkt_ack releases the next grant in the same cycle.
- cfg_we with port 0 → (leaf 17, port 9) issued in the same cycle as a port-0 grant → that packet carries the old routing; the next port-0 packet carries (17, 9). Return 10 credits to a full port → counter stays at 64 and credit_err=1.
- 130 grants on port 3 with returns keeping it eligible → seq wraps 127→0.
